// File: rtl/pic_timer_pkg.sv
// pic_timer_pkg: shared encodings and prescaler ratio table for the PIC timer family.
//   SRC_*   : src_sel encodings (clkout strobe / external pin)
//   EDGE_*  : edge_sel encodings (rising / falling external edge)
//   PS_MAX  : terminal prescaler count per ps setting, ratio 2^(ps+1)
package pic_timer_pkg;

    localparam logic SRC_CLKOUT = 1'b0;
    localparam logic SRC_EXT    = 1'b1;

    localparam logic EDGE_RISE  = 1'b0;
    localparam logic EDGE_FALL  = 1'b1;

    localparam logic [7:0] PS_MAX [8] = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63, 8'd127, 8'd255};

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: 8-bit tick divider, ratio 2^(ps+1); bypassed when en=0.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the divider count (counter write)
//   tick_in    : input tick strobe
//   en         : 1 = divide, 0 = pass tick_in straight through (count held at 0)
//   ps         : ratio select
//   tick_out   : divided tick strobe, same cycle as the terminal input tick
module timer_prescaler
    import pic_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       tick_in,
    input  logic       en,
    input  logic [2:0] ps,
    output logic       tick_out
);

    logic [7:0] cnt_q, cnt_d;
    logic       at_max;

    assign at_max = (cnt_q == PS_MAX[ps]);

    always_comb begin
        tick_out = en ? (tick_in & at_max) : tick_in;
        cnt_d    = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (tick_in) begin
            // A count above the new terminal (ps lowered) simply wraps through 255.
            cnt_d = at_max ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pic_timer_gen.sv
// pic_timer_gen: WIDTH-bit TMR1/TMR2-class timer.
//   clk, rst_n            : Fosc, asynchronous active-low reset
//   clkout_en             : Fosc/4 internal tick strobe
//   ext_clk_in, edge_sel  : async external clock pin and its active edge
//   src_sel               : tick source select
//   gate_en/gate_in/gate_pol : optional async gate and its polarity
//   ps_en, ps             : prescaler enable and ratio
//   period_en, period_in  : period-match mode and match value
//   post                  : postscaler select (ratio post+1)
//   wr_lo, wr_hi, rd_lo, data_in : 8-bit register bus with atomic 16-bit access
//   cnt_lo_out, cnt_hi_out: live low byte, latched high byte
//   flag_set_en, tmr_out  : postscaled interrupt strobe, event toggle output
module pic_timer_gen
    import pic_timer_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned POST_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clkout_en,
    input  logic                 ext_clk_in,
    input  logic                 src_sel,
    input  logic                 edge_sel,
    input  logic                 gate_en,
    input  logic                 gate_in,
    input  logic                 gate_pol,
    input  logic                 ps_en,
    input  logic [2:0]           ps,
    input  logic                 period_en,
    input  logic [WIDTH-1:0]     period_in,
    input  logic [POST_BITS-1:0] post,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic                 rd_lo,
    input  logic [7:0]           data_in,
    output logic [7:0]           cnt_lo_out,
    output logic [7:0]           cnt_hi_out,
    output logic                 flag_set_en,
    output logic                 tmr_out
);

    logic                 ext_s1_q, ext_s2_q, ext_prev_q, ext_tick_q;
    logic                 gate_s1_q, gate_s2_q;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [7:0]           hi_buf_q, rd_buf_q;
    logic [POST_BITS-1:0] post_q, post_d;
    logic                 flag_q, flag_d;
    logic                 tout_q;
    logic                 ext_edge, raw_tick, gate_act, tick, ps_tick, event_hit;
    logic [15:0]          cnt_ext, load_val;

    assign cnt_ext  = 16'(cnt_q);
    assign load_val = (WIDTH == 16) ? {hi_buf_q, data_in} : {8'h00, data_in};

    always_comb begin
        unique case (edge_sel)
            EDGE_RISE: ext_edge = ext_s2_q & ~ext_prev_q;
            EDGE_FALL: ext_edge = ~ext_s2_q & ext_prev_q;
            default:   ext_edge = 1'b0;
        endcase
        unique case (src_sel)
            SRC_CLKOUT: raw_tick = clkout_en;
            SRC_EXT:    raw_tick = ext_tick_q;
            default:    raw_tick = 1'b0;
        endcase
        gate_act = gate_pol ? gate_s2_q : ~gate_s2_q;
        tick     = raw_tick & (~gate_en | gate_act);
    end

    timer_prescaler u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wr_lo),
        .tick_in  (tick),
        .en       (ps_en),
        .ps       (ps),
        .tick_out (ps_tick)
    );

    always_comb begin
        cnt_d     = cnt_q;
        event_hit = 1'b0;
        if (wr_lo) begin
            // A counter write swallows any coincident tick.
            cnt_d = WIDTH'(load_val);
        end else if (ps_tick) begin
            if (period_en && (cnt_q == period_in)) begin
                cnt_d     = '0;
                event_hit = 1'b1;
            end else begin
                // In period mode an overshoot runs to all-ones and wraps without an event.
                cnt_d     = cnt_q + WIDTH'(1);
                event_hit = ~period_en & (&cnt_q);
            end
        end

        post_d = post_q;
        flag_d = 1'b0;
        if (event_hit) begin
            if (post_q == post) begin
                post_d = '0;
                flag_d = 1'b1;
            end else begin
                post_d = post_q + POST_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_s1_q   <= 1'b0;
            ext_s2_q   <= 1'b0;
            ext_prev_q <= 1'b0;
            ext_tick_q <= 1'b0;
            gate_s1_q  <= 1'b0;
            gate_s2_q  <= 1'b0;
            cnt_q      <= '0;
            hi_buf_q   <= '0;
            rd_buf_q   <= '0;
            post_q     <= '0;
            flag_q     <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            ext_s1_q   <= ext_clk_in;
            ext_s2_q   <= ext_s1_q;
            ext_prev_q <= ext_s2_q;
            // Registered edge strobe: pin edge at clk edge k reaches the counter at k+3.
            ext_tick_q <= ext_edge;
            gate_s1_q  <= gate_in;
            gate_s2_q  <= gate_s1_q;
            cnt_q      <= cnt_d;
            if (wr_hi && (WIDTH == 16)) begin
                hi_buf_q <= data_in;
            end
            if (rd_lo) begin
                rd_buf_q <= cnt_ext[15:8];
            end
            post_q     <= post_d;
            flag_q     <= flag_d;
            tout_q     <= tout_q ^ event_hit;
        end
    end

    assign cnt_lo_out  = cnt_ext[7:0];
    assign cnt_hi_out  = rd_buf_q;
    assign flag_set_en = flag_q;
    assign tmr_out     = tout_q;

endmodule

// File: tb/tb_pic_timer_gen.sv
// tb_pic_timer_gen: self-checking bench for pic_timer_gen (WIDTH=16, POST_BITS=4).
module tb_pic_timer_gen;

    localparam int unsigned W  = 16;
    localparam int unsigned PB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clkout_en = 1'b0, ext_clk_in = 1'b0, src_sel = 1'b0, edge_sel = 1'b0;
    logic          gate_en = 1'b0, gate_in = 1'b0, gate_pol = 1'b0, ps_en = 1'b0;
    logic [2:0]    ps = '0;
    logic          period_en = 1'b0;
    logic [W-1:0]  period_in = '0;
    logic [PB-1:0] post = '0;
    logic          wr_lo = 1'b0, wr_hi = 1'b0, rd_lo = 1'b0;
    logic [7:0]    data_in = '0;
    logic [7:0]    cnt_lo_out, cnt_hi_out;
    logic          flag_set_en, tmr_out;

    always #5 clk = ~clk;

    pic_timer_gen #(
        .WIDTH     (W),
        .POST_BITS (PB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clkout_en   (clkout_en),
        .ext_clk_in  (ext_clk_in),
        .src_sel     (src_sel),
        .edge_sel    (edge_sel),
        .gate_en     (gate_en),
        .gate_in     (gate_in),
        .gate_pol    (gate_pol),
        .ps_en       (ps_en),
        .ps          (ps),
        .period_en   (period_en),
        .period_in   (period_in),
        .post        (post),
        .wr_lo       (wr_lo),
        .wr_hi       (wr_hi),
        .rd_lo       (rd_lo),
        .data_in     (data_in),
        .cnt_lo_out  (cnt_lo_out),
        .cnt_hi_out  (cnt_hi_out),
        .flag_set_en (flag_set_en),
        .tmr_out     (tmr_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: 16-bit count as an integer, prescaler as ticks modulo the ratio.
    bit model_on = 1'b0;
    int m_cnt, m_pre, m_post, m_hi, m_rd;
    bit m_flag, m_tout;

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_post = 0; m_hi = 0; m_rd = 0; m_flag = 0; m_tout = 0;
    endtask

    task automatic model_step();
        int  ratio;
        int  old_cnt;
        int  old_hi;
        bit  fire;
        bit  ev;
        ratio   = 1 << (int'(ps) + 1);
        old_cnt = m_cnt;
        old_hi  = m_hi;
        ev      = 0;
        m_flag  = 0;
        if (!ps_en) m_pre = 0;
        if (wr_lo) begin
            m_cnt = old_hi * 256 + int'(data_in);
            m_pre = 0;
        end else if (clkout_en && (!gate_en || (gate_in == gate_pol))) begin
            fire = 1;
            if (ps_en) begin
                m_pre = (m_pre + 1) % ratio;
                fire  = (m_pre == 0);
            end
            if (fire) begin
                if (period_en && m_cnt == int'(period_in)) begin
                    m_cnt = 0;
                    ev    = 1;
                end else begin
                    ev    = !period_en && m_cnt == 65535;
                    m_cnt = (m_cnt + 1) % 65536;
                end
            end
        end
        if (ev) begin
            m_tout = !m_tout;
            if (m_post == int'(post)) begin
                m_post = 0;
                m_flag = 1;
            end else begin
                m_post = (m_post + 1) % (1 << PB);
            end
        end
        if (wr_hi) m_hi = int'(data_in);
        if (rd_lo) m_rd = old_cnt / 256;
    endtask

    task automatic cyc();
        if (model_on) model_step();
        @(posedge clk);
        #1;
        if (model_on) begin
            chk("model_lo", 32'(cnt_lo_out), 32'(m_cnt % 256));
            chk("model_hi", 32'(cnt_hi_out), 32'(m_rd));
            chk("model_flag", 32'(flag_set_en), 32'(m_flag));
            chk("model_tout", 32'(tmr_out), 32'(m_tout));
        end
    endtask

    task automatic idle();
        wr_hi = 0; wr_lo = 0; rd_lo = 0; clkout_en = 0;
    endtask

    task automatic write16(input logic [15:0] v);
        idle();
        wr_hi = 1; data_in = v[15:8]; cyc();
        wr_hi = 0; wr_lo = 1; data_in = v[7:0]; cyc();
        wr_lo = 0;
    endtask

    typedef struct {
        logic       wh, wl, rd, ck;
        logic [7:0] data;
        logic [7:0] e_lo, e_hi;
        logic       e_flag, e_tout;
    } vec_t;

    vec_t tv[16];

    initial begin
        int flags;
        int toggles;
        bit prev_t;
        logic [15:0] start;

        // Free-run / register-bus table, starting from reset.
        tv[0]  = '{1, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 0};
        tv[1]  = '{0, 1, 0, 0, 8'hFE, 8'hFE, 8'h00, 0, 0};
        tv[2]  = '{0, 0, 0, 1, 8'h00, 8'hFF, 8'h00, 0, 0};
        tv[3]  = '{0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 1, 1};
        tv[4]  = '{0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1};
        tv[5]  = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1};
        tv[6]  = '{1, 0, 0, 0, 8'h12, 8'h00, 8'h00, 0, 1};
        tv[7]  = '{0, 1, 0, 1, 8'h34, 8'h34, 8'h00, 0, 1};
        tv[8]  = '{0, 0, 1, 0, 8'h00, 8'h34, 8'h12, 0, 1};
        tv[9]  = '{0, 1, 0, 0, 8'hFF, 8'hFF, 8'h12, 0, 1};
        tv[10] = '{0, 0, 1, 1, 8'h00, 8'h00, 8'h12, 0, 1};
        tv[11] = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h13, 0, 1};
        tv[12] = '{1, 0, 0, 1, 8'hAB, 8'h01, 8'h13, 0, 1};
        tv[13] = '{0, 1, 0, 0, 8'h00, 8'h00, 8'h13, 0, 1};
        tv[14] = '{0, 0, 1, 0, 8'h00, 8'h00, 8'hAB, 0, 1};
        tv[15] = '{0, 0, 0, 0, 8'h00, 8'h00, 8'hAB, 0, 1};

        // Reset state.
        model_reset();
        #12;
        chk("reset_lo", 32'(cnt_lo_out), 32'h0);
        chk("reset_hi", 32'(cnt_hi_out), 32'h0);
        chk("reset_flag", 32'(flag_set_en), 32'h0);
        chk("reset_tout", 32'(tmr_out), 32'h0);
        rst_n = 1;
        model_on = 1;
        cyc();

        foreach (tv[i]) begin
            wr_hi = tv[i].wh; wr_lo = tv[i].wl; rd_lo = tv[i].rd; clkout_en = tv[i].ck;
            data_in = tv[i].data;
            cyc();
            chk($sformatf("tv%0d_lo", i), 32'(cnt_lo_out), 32'(tv[i].e_lo));
            chk($sformatf("tv%0d_hi", i), 32'(cnt_hi_out), 32'(tv[i].e_hi));
            chk($sformatf("tv%0d_flag", i), 32'(flag_set_en), 32'(tv[i].e_flag));
            chk($sformatf("tv%0d_tout", i), 32'(tmr_out), 32'(tv[i].e_tout));
        end
        idle();

        // Prescaler 1:8, and a write mid-stream restarts the division.
        ps_en = 1; ps = 3'd2;
        write16(16'h0000);
        clkout_en = 1;
        repeat (16) cyc();
        chk("ps_16_ticks", 32'(cnt_lo_out), 32'd2);
        repeat (5) cyc();
        clkout_en = 0; wr_lo = 1; data_in = 8'h00; cyc(); wr_lo = 0;
        clkout_en = 1;
        repeat (7) cyc();
        chk("ps_restart_7", 32'(cnt_lo_out), 32'd0);
        cyc();
        chk("ps_restart_8", 32'(cnt_lo_out), 32'd1);
        idle();

        // Period mode, period 5, postscale 1:3.
        ps_en = 0; period_en = 1; period_in = 16'd5; post = 4'd2;
        write16(16'h0000);
        flags = 0; toggles = 0; prev_t = tmr_out;
        clkout_en = 1;
        for (int i = 0; i < 18; i++) begin
            cyc();
            chk($sformatf("period_seq%0d", i), 32'(cnt_lo_out), 32'((i + 1) % 6));
            if (flag_set_en) flags++;
            if (tmr_out != prev_t) toggles++;
            prev_t = tmr_out;
        end
        idle();
        cyc();
        if (flag_set_en) flags++;
        chk("period_flags", 32'(flags), 32'd1);
        chk("period_toggles", 32'(toggles), 32'd3);

        // Randomised segments against the model.
        for (int seg = 0; seg < 20; seg++) begin
            idle();
            period_en = 1'($urandom % 2);
            period_in = ($urandom % 2) ? 16'($urandom_range(0, 12)) : 16'($urandom);
            post      = 4'($urandom_range(0, 3));
            ps_en     = ($urandom % 3) == 0;
            ps        = 3'($urandom_range(0, 2));
            gate_en   = 1'($urandom % 2);
            gate_pol  = 1'($urandom % 2);
            gate_in   = 1'($urandom % 2);
            repeat (3) cyc();
            case ($urandom % 3)
                0:       start = period_in - 16'd2;
                1:       start = 16'hFFFD;
                default: start = 16'($urandom);
            endcase
            write16(start);
            for (int c = 0; c < 60; c++) begin
                clkout_en = ($urandom % 4) != 0;
                rd_lo     = ($urandom % 6) == 0;
                wr_lo     = ($urandom % 30) == 0;
                wr_hi     = !wr_lo && (($urandom % 25) == 0);
                data_in   = 8'($urandom);
                if (($urandom % 40) == 0) period_in = 16'($urandom_range(0, 12));
                cyc();
            end
        end
        idle();

        // External falling edge source with an active-high gate.
        model_on = 0;
        src_sel = 1; edge_sel = 1; gate_en = 1; gate_pol = 1; gate_in = 1;
        ps_en = 0; period_en = 0; ext_clk_in = 1;
        repeat (4) cyc();
        write16(16'h0000);
        for (int n = 0; n < 4; n++) begin
            ext_clk_in = 0;
            cyc(); cyc();
            chk($sformatf("ext_k1_%0d", n), 32'(cnt_lo_out), 32'(n));
            cyc();
            chk($sformatf("ext_k2_%0d", n), 32'(cnt_lo_out), 32'(n));
            cyc();
            chk($sformatf("ext_k3_%0d", n), 32'(cnt_lo_out), 32'(n + 1));
            ext_clk_in = 1;
            repeat (3) cyc();
        end
        gate_in = 0;
        repeat (3) cyc();
        for (int n = 0; n < 4; n++) begin
            ext_clk_in = 0;
            repeat (4) cyc();
            ext_clk_in = 1;
            repeat (4) cyc();
        end
        chk("ext_gated_off", 32'(cnt_lo_out), 32'd4);

        // Asynchronous reset mid-count.
        src_sel = 0; edge_sel = 0; gate_en = 0;
        write16(16'h55F0);
        rd_lo = 1; cyc(); rd_lo = 0;
        clkout_en = 1; cyc(); cyc(); clkout_en = 0;
        chk("pre_rst_lo", 32'(cnt_lo_out), 32'hF2);
        chk("pre_rst_hi", 32'(cnt_hi_out), 32'h55);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_lo", 32'(cnt_lo_out), 32'h0);
        chk("async_rst_hi", 32'(cnt_hi_out), 32'h0);
        chk("async_rst_flag", 32'(flag_set_en), 32'h0);
        chk("async_rst_tout", 32'(tmr_out), 32'h0);
        #1;
        rst_n = 1;
        model_reset();
        model_on = 1;
        cyc();
        clkout_en = 1; cyc(); clkout_en = 0;
        chk("post_rst_lo", 32'(cnt_lo_out), 32'h01);
        chk("post_rst_hi", 32'(cnt_hi_out), 32'h00);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
